mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master round-robin arbiter for the PicoRV32-style native memory bus (valid/ready, 32-bit addr/wdata/rdata, 4-bit wstrb). Sits between the CPU and a second bus master (the planned NTT coefficient DMA) on one side, and the shared slave bus (address decode to ROM, data RAM, NTT accelerator, UART) on the other. Serialises transactions, holds each grant until the slave responds, and optionally terminates hung transactions with a bus timeout.

## Interface
- TIMEOUT_CYCLES, 256: BUSY cycles without s_ready before forced completion (used only with timeout compiled in; minimum 2).
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- m0_valid / m1_valid  input  1  master request.
- m0_addr / m1_addr  input  32  byte address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wstrb / m1_wstrb  input  4  byte strobes; 0 means read.
- m0_ready / m1_ready  output  1  transaction completion pulse to the master.
- m0_rdata / m1_rdata  output  32  read data; valid while the matching ready is high.
- s_valid  output  1  request to the slave bus.
- s_addr  output  32  muxed address.
- s_wdata  output  32  muxed write data.
- s_wstrb  output  4  muxed strobes.
- s_ready  input  1  slave completion.
- s_rdata  input  32  slave read data.
- grant  output  2  one-hot current owner; 00 in IDLE.
- timeout_clr  input  1  clears timeout_flag.
- timeout_flag  output  1  sticky; set on a forced completion.

## Operation
- States: IDLE, BUSY. Registers: state, owner (0/1), last (master most recently completed), and the timeout counter when compiled in.
- IDLE: if any mN_valid is high, grant the requester. If both request, grant the master that is not `last`. Go to BUSY at the next edge. No s_valid is driven in IDLE.
- BUSY: s_addr, s_wdata, s_wstrb and s_valid follow the owner's inputs combinationally. m_owner_ready equals s_ready and m_owner_rdata equals s_rdata. The non-owner's ready and rdata are 0.
- BUSY → IDLE on s_ready & s_valid; `last` ← owner.
- Owner drops valid while in BUSY (protocol violation): s_valid falls at the same time. Go to IDLE without a ready pulse; `last` is unchanged.
- A new request is never granted in the same cycle another completes. Every transaction passes through at least one IDLE cycle.
- A non-owner request stays pending indefinitely without being dropped. Its ready output stays 0.
- Reset (asynchronous, effective mid-transaction):
  - state=IDLE, last=1 (so m0 wins the first tie), counter=0, timeout_flag=0.
  - All outputs are 0 while rst is high.
  - An interrupted slave access is abandoned.

## Timing
- Request sampled in IDLE at edge k. s_valid is high in cycle k+1.
- A zero-wait slave (s_ready combinational in cycle k+1) gives mN_ready in cycle k+1. Arbitration cost is one cycle per transaction.
- Slave-bus and master-response paths are combinational through the owner mux. grant and state are registered.
- timeout_clr and a new timeout event in the same cycle: the set wins.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - In the BUSY cycle where counter == TIMEOUT_CYCLES-1 and s_ready is low, the arbiter forces completion:
    - s_valid is forced to 0;
    - m_owner_ready = 1;
    - m_owner_rdata = 32'hDEAD_BEEF;
    - timeout_flag ← 1;
    - next state IDLE; `last` ← owner.
- ARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely, timeout_flag is tied 0 and timeout_clr is ignored.

## Structure
- Package mem_bus_pkg holds:
  - bus widths BUS_AW=32, BUS_DW=32, BUS_SW=4;
  - the state enum (IDLE, BUSY);
  - TIMEOUT_RDATA=32'hDEAD_BEEF.
- One sub-module, bus_timeout_ctr: counter, expiry compare and sticky flag. It is instantiated only under ARB_TIMEOUT_EN.

## Test plan
- Single read: m0 reads 0x0001_0000, slave ready 2 cycles after s_valid with rdata 0x1234_5678.
  - grant=01.
  - s_valid is high for 3 cycles.
  - m0_ready pulses once with 0x1234_5678.
  - m1_ready stays 0.
- Simultaneous requests after reset, both held high:
  - service order is m0, m1, m0, m1;
  - one IDLE cycle between each transaction.
- Write passthrough: m1 writes 0xCAFE_F00D, wstrb 4'b0011, to 0x1000_0004.
  - s_addr, s_wdata and s_wstrb match exactly while s_valid is high.
  - m0 stays pending with m0_ready=0 until m1 completes.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16), s_ready held 0:
  - m0_ready with 0xDEAD_BEEF in the 16th BUSY cycle;
  - timeout_flag=1 and stays set;
  - timeout_clr clears it the next cycle.
- Reset mid-BUSY: rst asserted asynchronously, between clock edges.
  - s_valid, grant and mN_ready are 0 immediately.
  - After release, a tie goes to m0.
- Valid withdrawn: m1 drops valid in BUSY before s_ready.
  - s_valid falls in the same cycle;
  - no m1_ready pulse;
  - IDLE next cycle;
  - the next tie still favours the non-`last` master.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared widths, FSM state type and request payload for the two-master
// round-robin memory bus arbiter (PicoRV32-style valid/ready bus).
// Contents: BUS_AW/BUS_DW/BUS_SW widths, arb_state_e, bus_req_t,
//           TIMEOUT_RDATA (read data returned on a forced completion).
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [BUS_DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Request payload carried from the owning master to the slave bus
  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_SW-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// One native memory bus link (valid/ready, addr/wdata/wstrb, rdata).
// Modports:
//   master : drives valid/addr/wdata/wstrb, receives ready/rdata
//   slave  : receives valid/addr/wdata/wstrb, drives ready/rdata
// wstrb == 0 marks a read.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
();

  logic              valid;
  logic [BUS_AW-1:0] addr;
  logic [BUS_DW-1:0] wdata;
  logic [BUS_SW-1:0] wstrb;
  logic              ready;
  logic [BUS_DW-1:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/bus_timeout_ctr.sv
// -----------------------------------------------------------------------------
// bus_timeout_ctr
// Counts BUSY cycles without slave completion, flags expiry and keeps a sticky
// timeout flag. Only instantiated when ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst      : clock, async active-high reset
//   i_start       : grant issued this cycle (next cycle is first BUSY cycle)
//   i_busy        : arbiter BUSY with a live owner request
//   i_s_ready     : slave completion
//   i_clr         : clear sticky flag (a same-cycle expiry wins)
//   o_expire_c    : combinational, force completion this cycle
//   o_flag        : sticky timeout flag
// -----------------------------------------------------------------------------
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_busy,
  input  logic i_s_ready,
  input  logic i_clr,
  output logic o_expire_c,
  output logic o_flag
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_flag;

  // Expiry in the BUSY cycle whose index (from 0) reaches TIMEOUT_CYCLES-1
  always_comb begin
    o_expire_c = i_busy & ~i_s_ready & (r_cnt == LAST_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      if (i_start) begin
        r_cnt <= '0;
      end else if (i_busy && !i_s_ready && !o_expire_c) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (o_expire_c) begin
        r_flag <= 1'b1;
      end else if (i_clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Two-master round-robin arbiter onto one shared slave bus. A grant is held
// until the slave completes (or the owner withdraws); every transaction is
// followed by at least one IDLE cycle. Slave request and master response
// paths are combinational through the owner mux; grant/state are registered.
// Optional build macro: ARB_TIMEOUT_EN (forced completion after
// TIMEOUT_CYCLES BUSY cycles, returning TIMEOUT_RDATA and setting a sticky
// timeout_flag). Without it timeout_flag is 0 and timeout_clr is ignored.
// Ports:
//   clk, rst       : clock, async active-high reset
//   m0, m1         : master links (slave modport)
//   s              : shared slave link (master modport)
//   grant          : one-hot owner, 00 in IDLE
//   timeout_clr    : clears timeout_flag
//   timeout_flag   : sticky forced-completion indicator
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_bus_arbiter_if.slave        m0,
  mem_bus_arbiter_if.slave        m1,
  mem_bus_arbiter_if.master       s,
  output logic [1:0]              grant,
  input  logic                    timeout_clr,
  output logic                    timeout_flag
);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_last;
  logic [1:0]        r_grant;

  logic              w_busy;
  logic              w_own_valid;
  logic              w_any_req;
  logic              w_pick;
  logic              w_expire;
  logic              w_done;
  logic              w_flag;
  bus_req_t          w_req;
  logic [BUS_DW-1:0] w_rdata;

  // Owner mux, slave request and master response paths
  always_comb begin
    w_busy      = (r_state == BUSY);
    w_any_req   = m0.valid | m1.valid;
    // Tie goes to the master that did not complete last
    w_pick      = (m0.valid & m1.valid) ? ~r_last : m1.valid;
    w_own_valid = r_owner ? m1.valid : m0.valid;
    w_req       = r_owner ? {m1.addr, m1.wdata, m1.wstrb}
                          : {m0.addr, m0.wdata, m0.wstrb};

    s.valid = w_busy & w_own_valid & ~w_expire;
    s.addr  = w_busy ? w_req.addr  : '0;
    s.wdata = w_busy ? w_req.wdata : '0;
    s.wstrb = w_busy ? w_req.wstrb : '0;

    // Withdrawn request never completes, even if the slave answers
    w_done  = (s.valid & s.ready) | w_expire;
    w_rdata = w_expire ? TIMEOUT_RDATA : s.rdata;

    m0.ready = w_done & ~r_owner;
    m1.ready = w_done &  r_owner;
    m0.rdata = (w_busy & ~r_owner) ? w_rdata : '0;
    m1.rdata = (w_busy &  r_owner) ? w_rdata : '0;
  end

  // Arbitration FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state <= BUSY;
            r_owner <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
          end
        end
        BUSY: begin
          if (!w_own_valid) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
          end else if (w_done) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_last  <= r_owner;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign grant = r_grant;

`ifdef ARB_TIMEOUT_EN
  logic w_start;
  assign w_start = (r_state == IDLE) & w_any_req;

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_busy     (w_busy & w_own_valid),
    .i_s_ready  (s.ready),
    .i_clr      (timeout_clr),
    .o_expire_c (w_expire),
    .o_flag     (w_flag)
  );
`else
  logic              w_unused_clr;
  logic [31:0]       w_unused_param;
  assign w_expire       = 1'b0;
  assign w_flag         = 1'b0;
  assign w_unused_clr   = timeout_clr;
  assign w_unused_param = 32'(TIMEOUT_CYCLES);
`endif

  assign timeout_flag = w_flag;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES = 16).
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout_clr;
  logic       timeout_flag;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mem_bus_arbiter_if m0_if ();
  mem_bus_arbiter_if m1_if ();
  mem_bus_arbiter_if s_if ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m0           (m0_if),
    .m1           (m1_if),
    .s            (s_if),
    .grant        (grant),
    .timeout_clr  (timeout_clr),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    timeout_clr  = 1'b0;
    m0_if.valid  = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
    m1_if.valid  = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
    s_if.ready   = 1'b0; s_if.rdata = '0;
    #1;
    chk("rst_grant",   32'(grant), 32'h0);
    chk("rst_s_valid", 32'(s_if.valid), 32'h0);
    chk("rst_m0_ready", 32'(m0_if.ready), 32'h0);
    chk("rst_flag",    32'(timeout_flag), 32'h0);
    tick();
    rst = 1'b0;

    // ---- Single read by m0, slave ready on third s_valid cycle ----
    tick();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0001_0000; m0_if.wstrb = 4'h0;
    #1;
    chk("rd_idle_s_valid", 32'(s_if.valid), 32'h0);
    chk("rd_idle_grant",   32'(grant), 32'h0);
    tick();
    chk("rd_grant",    32'(grant), 32'h1);
    chk("rd_s_valid1", 32'(s_if.valid), 32'h1);
    chk("rd_s_addr",   s_if.addr, 32'h0001_0000);
    chk("rd_m0_ready1", 32'(m0_if.ready), 32'h0);
    tick();
    chk("rd_s_valid2", 32'(s_if.valid), 32'h1);
    chk("rd_m0_ready2", 32'(m0_if.ready), 32'h0);
    tick();
    s_if.ready = 1'b1; s_if.rdata = 32'h1234_5678;
    #1;
    chk("rd_s_valid3", 32'(s_if.valid), 32'h1);
    chk("rd_m0_ready3", 32'(m0_if.ready), 32'h1);
    chk("rd_m0_rdata", m0_if.rdata, 32'h1234_5678);
    chk("rd_m1_ready", 32'(m1_if.ready), 32'h0);
    chk("rd_m1_rdata", m1_if.rdata, 32'h0);
    tick();
    s_if.ready = 1'b0; m0_if.valid = 1'b0;
    #1;
    chk("rd_done_grant",   32'(grant), 32'h0);
    chk("rd_done_s_valid", 32'(s_if.valid), 32'h0);
    chk("rd_done_m0_ready", 32'(m0_if.ready), 32'h0);

    // ---- Reset, then both masters held high with a zero-wait slave ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0100;
    m1_if.valid = 1'b1; m1_if.addr = 32'h0000_0200;
    s_if.ready  = 1'b1; s_if.rdata = 32'h0000_00AA;
    #1;
    chk("rr_idle0", 32'(grant), 32'h0);
    tick(); chk("rr_g1_m0", 32'(grant), 32'h1); chk("rr_g1_rdy", 32'(m0_if.ready), 32'h1);
    tick(); chk("rr_idle1", 32'(grant), 32'h0); chk("rr_idle1_sv", 32'(s_if.valid), 32'h0);
    tick(); chk("rr_g2_m1", 32'(grant), 32'h2); chk("rr_g2_rdy", 32'(m1_if.ready), 32'h1);
    chk("rr_g2_m0_rdy", 32'(m0_if.ready), 32'h0);
    tick(); chk("rr_idle2", 32'(grant), 32'h0);
    tick(); chk("rr_g3_m0", 32'(grant), 32'h1); chk("rr_g3_addr", s_if.addr, 32'h0000_0100);
    tick(); chk("rr_idle3", 32'(grant), 32'h0);
    tick(); chk("rr_g4_m1", 32'(grant), 32'h2); chk("rr_g4_addr", s_if.addr, 32'h0000_0200);
    tick();
    m0_if.valid = 1'b0; m1_if.valid = 1'b0; s_if.ready = 1'b0;
    tick();

    // ---- m1 write passthrough while m0 waits ----
    m1_if.valid = 1'b1; m1_if.addr = 32'h1000_0004;
    m1_if.wdata = 32'hCAFE_F00D; m1_if.wstrb = 4'b0011;
    tick();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0040; m0_if.wstrb = 4'h0;
    #1;
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_s_valid", 32'(s_if.valid), 32'h1);
    chk("wr_s_addr", s_if.addr, 32'h1000_0004);
    chk("wr_s_wdata", s_if.wdata, 32'hCAFE_F00D);
    chk("wr_s_wstrb", 32'(s_if.wstrb), 32'h3);
    chk("wr_m0_pend1", 32'(m0_if.ready), 32'h0);
    tick();
    chk("wr_s_wdata2", s_if.wdata, 32'hCAFE_F00D);
    chk("wr_m0_pend2", 32'(m0_if.ready), 32'h0);
    s_if.ready = 1'b1;
    #1;
    chk("wr_m1_ready", 32'(m1_if.ready), 32'h1);
    chk("wr_m0_pend3", 32'(m0_if.ready), 32'h0);
    tick();
    m1_if.valid = 1'b0; s_if.ready = 1'b0;
    #1;
    chk("wr_idle_grant", 32'(grant), 32'h0);
    chk("wr_idle_m0_rdy", 32'(m0_if.ready), 32'h0);
    tick();
    chk("wr_m0_grant", 32'(grant), 32'h1);
    chk("wr_m0_addr", s_if.addr, 32'h0000_0040);
    chk("wr_m0_wstrb", 32'(s_if.wstrb), 32'h0);
    s_if.ready = 1'b1; s_if.rdata = 32'h0000_0055;
    #1;
    chk("wr_m0_ready", 32'(m0_if.ready), 32'h1);
    tick();
    m0_if.valid = 1'b0; s_if.ready = 1'b0;
    tick();

    // ---- Asynchronous reset in the middle of a BUSY cycle ----
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0080;
    tick();
    chk("ar_grant", 32'(grant), 32'h1);
    s_if.ready = 1'b1;
    #1;
    chk("ar_m0_ready_pre", 32'(m0_if.ready), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_s_valid", 32'(s_if.valid), 32'h0);
    chk("ar_grant0", 32'(grant), 32'h0);
    chk("ar_m0_ready", 32'(m0_if.ready), 32'h0);
    chk("ar_m1_ready", 32'(m1_if.ready), 32'h0);
    chk("ar_s_addr", s_if.addr, 32'h0);
    s_if.ready = 1'b0;
    m1_if.valid = 1'b1; m1_if.addr = 32'h0000_0300; m1_if.wstrb = 4'h0;
    #1;
    rst = 1'b0;
    tick();
    chk("ar_tie_m0", 32'(grant), 32'h1);
    s_if.ready = 1'b1;
    tick();
    m0_if.valid = 1'b0; m1_if.valid = 1'b0; s_if.ready = 1'b0;
    tick();

    // ---- m1 withdraws valid while BUSY (last = m0 here) ----
    m1_if.valid = 1'b1;
    tick();
    chk("wd_grant", 32'(grant), 32'h2);
    chk("wd_s_valid1", 32'(s_if.valid), 32'h1);
    m1_if.valid = 1'b0;
    #1;
    chk("wd_s_valid0", 32'(s_if.valid), 32'h0);
    chk("wd_m1_ready", 32'(m1_if.ready), 32'h0);
    tick();
    chk("wd_idle", 32'(grant), 32'h0);
    chk("wd_m1_ready2", 32'(m1_if.ready), 32'h0);
    m0_if.valid = 1'b1; m1_if.valid = 1'b1;
    tick();
    chk("wd_tie_m1", 32'(grant), 32'h2);
    s_if.ready = 1'b1;
    tick();
    m0_if.valid = 1'b0; m1_if.valid = 1'b0; s_if.ready = 1'b0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // ---- Hung slave: forced completion in the 16th BUSY cycle ----
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0500;
    tick();
    for (int i = 1; i < 16; i++) begin
      chk("to_wait_ready", 32'(m0_if.ready), 32'h0);
      tick();
    end
    chk("to_ready", 32'(m0_if.ready), 32'h1);
    chk("to_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    chk("to_s_valid", 32'(s_if.valid), 32'h0);
    chk("to_m1_ready", 32'(m1_if.ready), 32'h0);
    tick();
    m0_if.valid = 1'b0;
    #1;
    chk("to_flag_set", 32'(timeout_flag), 32'h1);
    chk("to_idle", 32'(grant), 32'h0);
    tick();
    chk("to_flag_sticky", 32'(timeout_flag), 32'h1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    #1;
    chk("to_flag_clr", 32'(timeout_flag), 32'h0);
`else
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    #1;
    chk("noto_flag", 32'(timeout_flag), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
